// File: rtl/flit_pattern_gen.sv
// Packetised test-pattern flit source with a toggle counter over accepted flits.
// Define PATGEN_LFSR_EN to build the LFSR pattern (mode 1); otherwise mode 1 outputs zero.
module flit_pattern_gen #(
  parameter int N       = 25,
  parameter int PAYLOAD = 20,
  parameter int GAP     = 7,
  parameter int NUM_PKT = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [31:0]  seed,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [31:0]  tgl_cnt
);
  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = 16;
  localparam int unsigned KW = 7;
  localparam int unsigned PW = 7;
  localparam logic [CW-1:0] LAST_BEAT = CW'(PAYLOAD - 1);
  localparam logic [CW-1:0] LAST_PKT  = CW'(NUM_PKT - 1);
  localparam logic [CW-1:0] LAST_GAP  = CW'(GAP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAPW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] beat_q, beat_d, pkt_q, pkt_d, gap_q, gap_d;
  logic          odd_q, odd_d;
  logic [KW-1:0] walk_q, walk_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  flit_q, flit_d, prev_q, prev_d;
  logic [31:0]   tgl_q, tgl_d;
  logic          valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic          load;
  logic [W-1:0]  walk_ones, lfsr_flit;
  logic [7:0]    walk_inc;
  logic [32:0]   tgl_sum;

  function automatic logic [PW-1:0] popcnt(input logic [W-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(W); i++) c = c + PW'(v[i]);
    return c;
  endfunction

  // odd_q/walk_q encode the flit index: its parity and (index with LSB cleared) mod 2N
  assign walk_inc  = 8'(walk_q) + 8'd2;
  assign tgl_sum   = 33'(tgl_q) + 33'(popcnt(flit_q ^ prev_q));
  assign walk_ones = {W{1'b1}} << walk_d;

`ifdef PATGEN_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  assign lfsr_flit = W'({lfsr_next(lfsr_d), lfsr_d});

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == S_IDLE && start) lfsr_d = (seed == 32'd0) ? 32'd1 : seed;
    else if (state_q == S_SEND && out_ready) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 32'd1;
    else     lfsr_q <= lfsr_d;
  end
`else
  logic unused_seed;
  assign unused_seed = ^seed;
  assign lfsr_flit   = '0;
`endif

  // Next state, counters and pattern index
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    odd_d   = odd_q;
    walk_d  = walk_q;
    mode_d  = mode_q;
    prev_d  = prev_q;
    tgl_d   = tgl_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          beat_d  = '0;
          pkt_d   = '0;
          gap_d   = '0;
          odd_d   = 1'b0;
          walk_d  = '0;
          mode_d  = mode;
          prev_d  = '0;
          tgl_d   = '0;
          load    = 1'b1;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          tgl_d  = tgl_sum[32] ? 32'hFFFF_FFFF : tgl_sum[31:0];
          prev_d = flit_q;
          odd_d  = ~odd_q;
          if (odd_q) walk_d = (walk_inc >= 8'(W)) ? '0 : KW'(walk_inc);
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (pkt_q == LAST_PKT) begin
              state_d = S_DONE;
            end else begin
              pkt_d = pkt_q + CW'(1);
              if (GAP > 0) begin
                state_d = S_GAPW;
                gap_d   = '0;
              end else begin
                load = 1'b1;
              end
            end
          end else begin
            beat_d = beat_q + CW'(1);
            load   = 1'b1;
          end
        end
      end
      S_GAPW: begin
        if (gap_q == LAST_GAP) begin
          state_d = S_SEND;
          load    = 1'b1;
        end else begin
          gap_d = gap_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // Flit register reloads only when a new flit is presented; otherwise holds the last one
  always_comb begin
    flit_d = flit_q;
    if (load) begin
      unique case (mode_d)
        2'd0:    flit_d = odd_d ? '0 : '1;
        2'd1:    flit_d = lfsr_flit;
        2'd2:    flit_d = odd_d ? ~walk_ones : walk_ones;
        default: flit_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      pkt_q   <= '0;
      gap_q   <= '0;
      odd_q   <= 1'b0;
      walk_q  <= '0;
      mode_q  <= 2'd0;
      flit_q  <= '0;
      prev_q  <= '0;
      tgl_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      odd_q   <= odd_d;
      walk_q  <= walk_d;
      mode_q  <= mode_d;
      flit_q  <= flit_d;
      prev_q  <= prev_d;
      tgl_q   <= tgl_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tgl_cnt   = tgl_q;
  assign op_a      = flit_q[N-1:0];
  assign op_b      = flit_q[W-1:N];
endmodule
